// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and limits for the fetch/load-store memory port arbiter.
//   arb_state_t : IDLE (nothing outstanding) / WAIT (one access in flight)
//   owner_t     : which core port (fetch F or load/store D) owns an access
//   MEM_LAT_MIN/MEM_LAT_MAX : legal range of the memory read latency
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin picker.
//   req_i[0] = fetch port request, req_i[1] = load/store port request
//   last_i   = port granted most recently
//   gnt_o    = one-hot winner (2'b00 when nobody requests)
//   A lone requester always wins; on contention the port that was not
//   granted last wins, so neither port can starve the other.
// ---------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic [1:0] gnt_o
);

    // Pick the winner from the request vector and the previous grant.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == OWN_D) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port, word-addressed memory between the instruction
//   fetch port (f_*) and the load/store port (d_*). One access outstanding at
//   a time, round-robin arbitration, read data returned MEM_LAT cycles after
//   the memory strobe.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     f_req/f_addr               fetch request and byte address
//     f_gnt/f_rvalid/f_rdata     fetch accept pulse, data valid pulse, data
//     d_req/d_we/d_be/d_addr/d_wdata   load/store request
//     d_gnt/d_rvalid/d_rdata     data accept pulse, completion pulse, load data
//     mem_en/mem_we/mem_be/mem_addr/mem_wdata   memory macro command
//     mem_rdata                  memory read data (MEM_LAT cycles after mem_en)
//
//   Grant and the memory command are combinational in the issue cycle so a new
//   access can start in the very cycle the previous response returns, giving
//   one access every MEM_LAT cycles under back-to-back traffic.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT    = 1,
    parameter int WORDS_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  f_req,
    input  logic [31:0]           f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [31:0]           f_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [31:0]           d_addr,
    input  logic [31:0]           d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [WORDS_LOG2-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_bad_mem_lat
        $error("mem_port_arbiter: MEM_LAT=%0d outside legal range %0d..%0d",
               MEM_LAT, MEM_LAT_MIN, MEM_LAT_MAX);
    end

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_q,  last_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             we_q,    we_d;     // access in flight is a store

    logic [1:0]       req_s;
    logic [1:0]       pick_s;
    logic             resp_s;
    logic             slot_s;
    logic             issue_s;
    logic             d_wins_s;

    // Byte-offset bits and bits above the memory depth are deliberately ignored
    // (word access, addresses wrap modulo the memory size).
    logic             unused_s;
    assign unused_s = ^{f_addr[31:WORDS_LOG2+2], f_addr[1:0],
                        d_addr[31:WORDS_LOG2+2], d_addr[1:0]};

    assign req_s = {d_req, f_req};

    rr_arb2 u_rr_arb2 (
        .req_i  (req_s),
        .last_i (last_q),
        .gnt_o  (pick_s)
    );

    // Response cycle doubles as an issue slot so accesses can pipeline.
    assign resp_s   = (state_q == WAIT) && (cnt_q == CNT_LAST);
    assign slot_s   = (state_q == IDLE) || resp_s;
    assign issue_s  = slot_s && (pick_s != 2'b00);
    assign d_wins_s = pick_s[1];

    // State, owner, round-robin history and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_F;
            last_q  <= OWN_D;
            cnt_q   <= {CNT_W{1'b0}};
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
        end
    end

    // Next-state: start a new access in an issue slot, otherwise count latency.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        if (issue_s) begin
            state_d = WAIT;
            owner_d = d_wins_s ? OWN_D : OWN_F;
            last_d  = d_wins_s ? OWN_D : OWN_F;
            cnt_d   = {CNT_W{1'b0}};
            we_d    = d_wins_s & d_we;
        end else if (slot_s) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else if (state_q == WAIT) begin
            cnt_d   = cnt_q + CNT_ONE;
        end else begin
            cnt_d   = {CNT_W{1'b0}};
        end
    end

    // Grant pulses and memory command; everything is held at zero in reset so
    // a request raised during reset cannot leak a grant or strobe.
    always_comb begin
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = {WORDS_LOG2{1'b0}};
        mem_wdata = 32'h0000_0000;
        if (issue_s && rst_n) begin
            mem_en = 1'b1;
            if (d_wins_s) begin
                d_gnt     = 1'b1;
                mem_we    = d_we;
                mem_be    = d_we ? d_be : 4'hF;
                mem_addr  = d_addr[WORDS_LOG2+1:2];
                mem_wdata = d_we ? d_wdata : 32'h0000_0000;
            end else begin
                f_gnt     = 1'b1;
                mem_be    = 4'hF;
                mem_addr  = f_addr[WORDS_LOG2+1:2];
            end
        end else begin
            mem_en = 1'b0;
        end
    end

    // Response routing: only the owning port sees rvalid; stores return zero.
    always_comb begin
        f_rvalid = 1'b0;
        f_rdata  = 32'h0000_0000;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0000_0000;
        if (resp_s) begin
            if (owner_q == OWN_D) begin
                d_rvalid = 1'b1;
                d_rdata  = we_q ? 32'h0000_0000 : mem_rdata;
            end else begin
                f_rvalid = 1'b1;
                f_rdata  = mem_rdata;
            end
        end else begin
            f_rvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Three arbiter instances (MEM_LAT = 1, 2, 3) share one set of request
//   inputs; each has its own behavioural memory preloaded with
//   word[i] = 32'h1000_0000 + i. Each directed scenario checks one instance
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic [2:0]  f_gnt_a;
    logic [2:0]  f_rvalid_a;
    logic [2:0]  d_gnt_a;
    logic [2:0]  d_rvalid_a;
    logic [2:0]  mem_en_a;
    logic [2:0]  mem_we_a;
    logic [31:0] f_rdata_a   [3];
    logic [31:0] d_rdata_a   [3];
    logic [31:0] mem_wdata_a [3];
    logic [3:0]  mem_be_a    [3];
    logic [4:0]  mem_addr_a  [3];

    int checks_cnt = 0;
    int errors_cnt = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [31:0] mem_m  [32];
        logic [31:0] pipe_m [4];
        logic [31:0] mem_rdata_w;

        initial begin
            for (int i = 0; i < 32; i++) mem_m[i] = 32'h1000_0000 + i;
        end

        // Behavioural single-port memory with LAT-cycle read latency.
        always @(posedge clk) begin
            if (mem_en_a[g]) begin
                if (mem_we_a[g]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be_a[g][b]) mem_m[mem_addr_a[g]][8*b +: 8] <= mem_wdata_a[g][8*b +: 8];
                    end
                end
                pipe_m[0] <= mem_m[mem_addr_a[g]];
            end else begin
                pipe_m[0] <= 32'h0BAD_0BAD;
            end
            for (int k = 1; k < 4; k++) pipe_m[k] <= pipe_m[k-1];
        end
        assign mem_rdata_w = pipe_m[LAT-1];

        mem_port_arbiter #(.MEM_LAT(LAT), .WORDS_LOG2(5)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .f_req     (f_req),
            .f_addr    (f_addr),
            .f_gnt     (f_gnt_a[g]),
            .f_rvalid  (f_rvalid_a[g]),
            .f_rdata   (f_rdata_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_be      (d_be),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_a[g]),
            .d_rvalid  (d_rvalid_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_be    (mem_be_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_w)
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        f_req   = 1'b0;
        f_addr  = 32'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_be    = 4'h0;
        d_addr  = 32'h0;
        d_wdata = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        smp();
        chk("rst_f_gnt",    32'(f_gnt_a[0]),    32'h0);
        chk("rst_d_gnt",    32'(d_gnt_a[0]),    32'h0);
        chk("rst_mem_en",   32'(mem_en_a[0]),   32'h0);
        chk("rst_mem_we",   32'(mem_we_a[0]),   32'h0);
        chk("rst_mem_addr", 32'(mem_addr_a[0]), 32'h0);
        chk("rst_mem_be",   32'(mem_be_a[0]),   32'h0);
        chk("rst_f_rdata",  f_rdata_a[0],       32'h0);
        chk("rst_d_rvalid", 32'(d_rvalid_a[0]), 32'h0);
        tick();
        rst_n = 1'b1;

        // Reset asserted mid-WAIT on the MEM_LAT=2 instance.
        do_reset();
        tick();
        f_req = 1'b1; f_addr = 32'hC;
        smp();
        chk("t1_gnt", 32'(f_gnt_a[1]), 32'h1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_rst_gnt",    32'(f_gnt_a[1]),    32'h0);
        chk("t1_rst_rvalid", 32'(f_rvalid_a[1]), 32'h0);
        chk("t1_rst_mem_en", 32'(mem_en_a[1]),   32'h0);
        chk("t1_rst_addr",   32'(mem_addr_a[1]), 32'h0);
        chk("t1_rst_rdata",  f_rdata_a[1],       32'h0);
        chk("t1_rst_be",     32'(mem_be_a[1]),   32'h0);
        f_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("t1_no_rvalid", 32'(f_rvalid_a[1]), 32'h0);
            tick();
        end

        // Lone fetch, MEM_LAT=1.
        do_reset();
        tick();
        f_req = 1'b1; f_addr = 32'h8;
        smp();
        chk("t2_gnt",      32'(f_gnt_a[0]),    32'h1);
        chk("t2_d_gnt",    32'(d_gnt_a[0]),    32'h0);
        chk("t2_mem_en",   32'(mem_en_a[0]),   32'h1);
        chk("t2_mem_we",   32'(mem_we_a[0]),   32'h0);
        chk("t2_mem_be",   32'(mem_be_a[0]),   32'hF);
        chk("t2_mem_addr", 32'(mem_addr_a[0]), 32'h2);
        tick();
        f_req = 1'b0;
        smp();
        chk("t2_rvalid",   32'(f_rvalid_a[0]), 32'h1);
        chk("t2_rdata",    f_rdata_a[0],       32'h1000_0002);
        chk("t2_d_rvalid", 32'(d_rvalid_a[0]), 32'h0);
        tick();
        smp();
        chk("t2_rvalid_off", 32'(f_rvalid_a[0]), 32'h0);
        chk("t2_rdata_off",  f_rdata_a[0],       32'h0);

        // Contention out of reset, MEM_LAT=1: grants alternate F,D,F,D,F,D.
        do_reset();
        tick();
        f_req = 1'b1; f_addr = 32'h0;
        d_req = 1'b1; d_addr = 32'hC; d_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk("t3_f_gnt", 32'(f_gnt_a[0]), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t3_d_gnt", 32'(d_gnt_a[0]), (i % 2 == 1) ? 32'h1 : 32'h0);
            tick();
        end
        idle_inputs();

        // Aliasing and latency, MEM_LAT=3: 0x84 wraps to word 1.
        do_reset();
        tick();
        f_req = 1'b1; f_addr = 32'h84;
        smp();
        chk("t5_gnt",      32'(f_gnt_a[2]),    32'h1);
        chk("t5_mem_addr", 32'(mem_addr_a[2]), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            smp();
            chk("t5_wait_gnt",    32'(f_gnt_a[2]),    32'h0);
            chk("t5_wait_rvalid", 32'(f_rvalid_a[2]), 32'h0);
        end
        tick();
        smp();
        chk("t5_rvalid",  32'(f_rvalid_a[2]), 32'h1);
        chk("t5_rdata",   f_rdata_a[2],       32'h1000_0001);
        chk("t5_regrant", 32'(f_gnt_a[2]),    32'h1);
        tick();
        idle_inputs();

        // Store then load to the same word, MEM_LAT=1.
        do_reset();
        tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4; d_be = 4'h3; d_wdata = 32'hAABB_CCDD;
        smp();
        chk("t4_st_gnt",   32'(d_gnt_a[0]),    32'h1);
        chk("t4_st_we",    32'(mem_we_a[0]),   32'h1);
        chk("t4_st_be",    32'(mem_be_a[0]),   32'h3);
        chk("t4_st_addr",  32'(mem_addr_a[0]), 32'h1);
        chk("t4_st_wdata", mem_wdata_a[0],     32'hAABB_CCDD);
        tick();
        d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
        smp();
        chk("t4_st_ack",   32'(d_rvalid_a[0]), 32'h1);
        chk("t4_st_rdata", d_rdata_a[0],       32'h0);
        chk("t4_ld_gnt",   32'(d_gnt_a[0]),    32'h1);
        chk("t4_ld_be",    32'(mem_be_a[0]),   32'hF);
        chk("t4_ld_we",    32'(mem_we_a[0]),   32'h0);
        tick();
        d_req = 1'b0;
        smp();
        chk("t4_ld_rvalid", 32'(d_rvalid_a[0]), 32'h1);
        chk("t4_ld_rdata",  d_rdata_a[0],       32'h1000_CCDD);
        tick();
        idle_inputs();

        // Cancelled data request while F owns WAIT, MEM_LAT=2.
        do_reset();
        tick();
        f_req = 1'b1; f_addr = 32'h10;
        smp();
        chk("t6_f_gnt", 32'(f_gnt_a[1]), 32'h1);
        tick();
        f_req = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF;
        smp();
        chk("t6_d_gnt",  32'(d_gnt_a[1]),  32'h0);
        chk("t6_mem_en", 32'(mem_en_a[1]), 32'h0);
        chk("t6_mem_we", 32'(mem_we_a[1]), 32'h0);
        tick();
        idle_inputs();
        smp();
        chk("t6_f_rvalid", 32'(f_rvalid_a[1]), 32'h1);
        chk("t6_f_rdata",  f_rdata_a[1],       32'h1000_0004);
        chk("t6_d_gnt2",   32'(d_gnt_a[1]),    32'h0);
        chk("t6_mem_en2",  32'(mem_en_a[1]),   32'h0);
        tick();
        f_req = 1'b1; f_addr = 32'h8;
        smp();
        chk("t6_rd_gnt", 32'(f_gnt_a[1]), 32'h1);
        tick();
        f_req = 1'b0;
        smp();
        chk("t6_rd_wait", 32'(f_rvalid_a[1]), 32'h0);
        tick();
        smp();
        chk("t6_rd_rvalid", 32'(f_rvalid_a[1]), 32'h1);
        chk("t6_rd_rdata",  f_rdata_a[1],       32'h1000_0002);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
